// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grant over active-low REQ/GNT, bus parking,
// one-cycle turnaround between owners, early grant removal and a no-FRAME grant timeout.
module pci_bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16,
    parameter int ID_W        = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] REQ,
    input  logic                 FRAME,
    input  logic                 IRDY,
    output logic [N_MASTERS-1:0] GNT,
    output logic [ID_W-1:0]      GNT_ID,
    output logic                 BUS_BUSY,
    output logic                 TIMEOUT_ERR
);

    localparam int                CNT_W    = $clog2(GNT_TIMEOUT) + 1;
    localparam logic [ID_W-1:0]   PARK_ID  = ID_W'(PARK_MASTER);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(N_MASTERS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(GNT_TIMEOUT - 1);

    typedef enum logic [1:0] {ARB, PARK, GRANT, BUSY} state_t;

    state_t                 state, state_nx;
    logic [ID_W-1:0]        win, win_nx;
    logic [ID_W-1:0]        last, last_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   released, released_nx;
    logic                   timeout_nx;
    logic                   granting_nx;
    logic [N_MASTERS-1:0]   gnt_nx;
    logic [ID_W-1:0]        rr_winner;
    logic                   rr_found;
    logic                   any_req, own_req, other_req, bus_idle;

    assign bus_idle = FRAME & IRDY;
    assign any_req  = ~&REQ;

    // Rotating priority: first requester strictly above LAST, else wrap from 0 up to LAST.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!rr_found && !REQ[j] && (j > int'(last))) begin
                rr_winner = ID_W'(j);
                rr_found  = 1'b1;
            end
        end
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!rr_found && !REQ[j] && (j <= int'(last))) begin
                rr_winner = ID_W'(j);
                rr_found  = 1'b1;
            end
        end
    end

    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (ID_W'(j) == win) own_req = ~REQ[j];
            else                 other_req = other_req | ~REQ[j];
        end
    end

    always_comb begin
        state_nx    = state;
        win_nx      = win;
        last_nx     = last;
        cnt_nx      = cnt;
        released_nx = released;
        timeout_nx  = 1'b0;
        case (state)
            ARB: begin
                cnt_nx      = '0;
                released_nx = 1'b0;
                if (any_req) begin
                    state_nx = GRANT;
                    win_nx   = rr_winner;
                end else begin
                    state_nx = PARK;
                    win_nx   = PARK_ID;
                end
            end
            PARK: begin
                if (!FRAME) begin
                    state_nx    = BUSY;
                    win_nx      = PARK_ID;
                    last_nx     = PARK_ID;
                    released_nx = 1'b0;
                end else if (any_req && bus_idle) begin
                    // The parked master already owns GNT, so it skips the turnaround.
                    if (rr_winner == PARK_ID) begin
                        state_nx = GRANT;
                        win_nx   = PARK_ID;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = ARB;
                    end
                end
            end
            GRANT: begin
                if (!FRAME) begin
                    state_nx    = BUSY;
                    last_nx     = win;
                    cnt_nx      = '0;
                    released_nx = 1'b0;
                end else if (!own_req) begin
                    state_nx = ARB;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx   = ARB;
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    state_nx    = ARB;
                    released_nx = 1'b0;
                end else if (other_req) begin
                    released_nx = 1'b1;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    // Outputs are computed from the next state so they leave the flops directly.
    always_comb begin
        granting_nx = (state_nx == PARK) || (state_nx == GRANT) ||
                      ((state_nx == BUSY) && !released_nx);
        gnt_nx = '1;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (granting_nx && (ID_W'(j) == win_nx)) gnt_nx[j] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ARB;
            win         <= '0;
            last        <= LAST_RST;
            cnt         <= '0;
            released    <= 1'b0;
            GNT         <= '1;
            GNT_ID      <= '0;
            BUS_BUSY    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_nx;
            win         <= win_nx;
            last        <= last_nx;
            cnt         <= cnt_nx;
            released    <= released_nx;
            GNT         <= gnt_nx;
            BUS_BUSY    <= (state_nx == BUSY);
            TIMEOUT_ERR <= timeout_nx;
            if (granting_nx) GNT_ID <= win_nx;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed vector table, hand-built corner sequences and
// a randomized run against an owner/turnaround reference model.
module tb_pci_bus_arbiter;

    localparam int N    = 4;
    localparam int TO   = 16;
    localparam int PARK = 0;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] REQ = 4'hF;
    logic       FRAME = 1'b1;
    logic       IRDY = 1'b1;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       BUS_BUSY;
    logic       TIMEOUT_ERR;

    int n_pass  = 0;
    int n_total = 0;

    pci_bus_arbiter #(
        .N_MASTERS(N), .PARK_MASTER(PARK), .GNT_TIMEOUT(TO), .ID_W(2)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .FRAME(FRAME), .IRDY(IRDY),
        .GNT(GNT), .GNT_ID(GNT_ID), .BUS_BUSY(BUS_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] req;
        logic       frame;
        logic       irdy;
        logic [3:0] gnt;
        int         id;
        logic       busy;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_out(input string name, input logic [3:0] eg, input int eid,
                           input logic eb, input logic et);
        chk({name, " gnt"}, 32'(GNT), 32'(eg));
        if (eg != 4'hF) chk({name, " id"}, 32'(GNT_ID), 32'(eid));
        chk({name, " busy"}, 32'(BUS_BUSY), 32'(eb));
        chk({name, " timeout"}, 32'(TIMEOUT_ERR), 32'(et));
    endtask

    task automatic drive(input logic [3:0] r, input logic f, input logic i);
        REQ = r; FRAME = f; IRDY = i;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b0;
        drive(4'hF, 1'b1, 1'b1);
        @(negedge CLK);
        chk_out("reset", 4'hF, 0, 1'b0, 1'b0);
        chk("reset id", 32'(GNT_ID), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // ---------------- reference model ----------------
    bit m_gap, m_parked, m_txn, m_drop;
    int m_age, m_last, m_holder;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int m;
            m = (last + k) % N;
            if (!r[m[1:0]]) return m;
        end
        return -1;
    endfunction

    task automatic model_reset;
        m_gap = 1; m_parked = 0; m_txn = 0; m_drop = 0;
        m_age = 0; m_last = N - 1; m_holder = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic f, input logic i, output bit to_p);
        bit idle;
        int p;
        logic [3:0] own;
        idle = f && i;
        to_p = 0;
        own  = 4'b0001 << m_holder;
        if (m_gap) begin
            p = rr_pick(r, m_last);
            m_gap = 0;
            if (p < 0) begin m_parked = 1; m_holder = PARK; end
            else begin m_holder = p; m_age = 0; end
        end else if (m_parked) begin
            if (!f) begin
                m_parked = 0; m_txn = 1; m_drop = 0; m_last = PARK; m_holder = PARK;
            end else if (r != 4'hF && idle) begin
                m_parked = 0;
                p = rr_pick(r, m_last);
                if (p == PARK) begin m_holder = p; m_age = 0; end
                else m_gap = 1;
            end
        end else if (m_txn) begin
            if (idle) begin m_txn = 0; m_gap = 1; end
            else if ((~r & ~own) != 4'h0) m_drop = 1;
        end else begin
            if (!f) begin m_txn = 1; m_drop = 0; m_last = m_holder; end
            else if ((r & own) != 4'h0) m_gap = 1;
            else if (m_age == TO - 1) begin m_gap = 1; to_p = 1; end
            else m_age++;
        end
    endtask

    initial begin
        logic [3:0] eg;
        bit         et;
        int         fp, rq;
        logic [3:0] r;
        logic       f, i;

        tbl[0]  = '{4'hF, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[2]  = '{4'hB, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[3]  = '{4'hB, 1'b1, 1'b1, 4'hB, 2, 1'b0};
        tbl[4]  = '{4'hB, 1'b0, 1'b1, 4'hB, 2, 1'b1};
        tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'hB, 2, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 1'b0, 4'hB, 2, 1'b1};
        tbl[7]  = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[9]  = '{4'hF, 1'b0, 1'b1, 4'hE, 0, 1'b1};
        tbl[10] = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[11] = '{4'hE, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[12] = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[13] = '{4'hF, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[14] = '{4'hE, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[15] = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[16] = '{4'h7, 1'b1, 1'b1, 4'h7, 3, 1'b0};
        tbl[17] = '{4'h7, 1'b0, 1'b1, 4'h7, 3, 1'b1};
        tbl[18] = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[19] = '{4'hF, 1'b1, 1'b1, 4'hE, 0, 1'b0};
        tbl[20] = '{4'hD, 1'b1, 1'b0, 4'hE, 0, 1'b0};
        tbl[21] = '{4'hD, 1'b1, 1'b1, 4'hF, 0, 1'b0};
        tbl[22] = '{4'hD, 1'b1, 1'b1, 4'hD, 1, 1'b0};
        tbl[23] = '{4'hF, 1'b1, 1'b1, 4'hF, 0, 1'b0};

        // Directed vectors: parking, grant, transaction, park-owner start, direct grant.
        do_reset;
        for (int k = 0; k < 24; k++) begin
            drive(tbl[k].req, tbl[k].frame, tbl[k].irdy);
            step;
            chk_out($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].id, tbl[k].busy, 1'b0);
        end

        // Round-robin with all masters requesting; one turnaround cycle between owners.
        do_reset;
        drive(4'h0, 1'b1, 1'b1);
        step;
        chk_out("rr first", 4'hE, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drive(4'h0, 1'b0, 1'b0); step;
            drive(4'h0, 1'b0, 1'b0); step;
            drive(4'h0, 1'b1, 1'b0); step;
            drive(4'h0, 1'b1, 1'b1); step;
            chk_out($sformatf("rr gap%0d", k), 4'hF, 0, 1'b0, 1'b0);
            step;
            eg = ~(4'b0001 << (k % 4));
            chk_out($sformatf("rr grant%0d", k), eg, k % 4, 1'b0, 1'b0);
        end

        // Early grant removal while master 1 owns the bus.
        do_reset;
        drive(4'hD, 1'b1, 1'b1); step;
        chk_out("er grant", 4'hD, 1, 1'b0, 1'b0);
        drive(4'hD, 1'b0, 1'b0); step;
        chk_out("er busy", 4'hD, 1, 1'b1, 1'b0);
        drive(4'h5, 1'b0, 1'b0); step;
        chk_out("er release", 4'hF, 0, 1'b1, 1'b0);
        drive(4'hD, 1'b0, 1'b0); step;
        chk_out("er no regrant", 4'hF, 0, 1'b1, 1'b0);
        drive(4'h7, 1'b1, 1'b1); step;
        chk_out("er gap", 4'hF, 0, 1'b0, 1'b0);
        step;
        chk_out("er next", 4'h7, 3, 1'b0, 1'b0);

        // Timeout on master 2 after LAST has become 2; master 3 must win next.
        do_reset;
        drive(4'hB, 1'b1, 1'b1); step;
        chk_out("to g1", 4'hB, 2, 1'b0, 1'b0);
        drive(4'hB, 1'b0, 1'b1); step;
        drive(4'hF, 1'b1, 1'b1); step;
        chk_out("to idle", 4'hF, 0, 1'b0, 1'b0);
        drive(4'hB, 1'b1, 1'b1); step;
        chk_out("to g2", 4'hB, 2, 1'b0, 1'b0);
        drive(4'h3, 1'b1, 1'b1);
        for (int k = 1; k < TO; k++) begin
            step;
            chk_out($sformatf("to wait%0d", k), 4'hB, 2, 1'b0, 1'b0);
        end
        step;
        chk_out("to fire", 4'hF, 0, 1'b0, 1'b1);
        step;
        chk_out("to next", 4'h7, 3, 1'b0, 1'b0);
        for (int k = 1; k < TO; k++) step;
        chk_out("to hold3", 4'h7, 3, 1'b0, 1'b0);
        drive(4'h3, 1'b0, 1'b1); step;
        chk_out("to frame wins", 4'h7, 3, 1'b1, 1'b0);
        drive(4'hF, 1'b1, 1'b1); step;
        chk_out("to end", 4'hF, 0, 1'b0, 1'b0);

        // Asynchronous reset between edges while BUSY, then restart without idle.
        do_reset;
        drive(4'hB, 1'b1, 1'b1); step;
        drive(4'hB, 1'b0, 1'b0); step;
        chk_out("ar busy", 4'hB, 2, 1'b1, 1'b0);
        #3 RST = 1'b0;
        #1;
        chk_out("ar immediate", 4'hF, 0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        step;
        chk_out("ar restart", 4'hB, 2, 1'b0, 1'b0);

        // Randomized run against the reference model.
        do_reset;
        model_reset;
        fp = 20; rq = 4;
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: fp = 2;
                    1: fp = 20;
                    default: fp = 50;
                endcase
                case ($urandom_range(0, 2))
                    0: rq = 1;
                    1: rq = 4;
                    default: rq = 8;
                endcase
            end
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) >= rq);
            f = ($urandom_range(0, 99) >= fp);
            i = ($urandom_range(0, 3) != 0);
            drive(r, f, i);
            model_step(r, f, i, et);
            step;
            if (m_gap || (m_txn && m_drop)) eg = 4'hF;
            else eg = ~(4'b0001 << m_holder);
            chk_out($sformatf("rand%0d", c), eg, m_holder, m_txn, et);
            chk($sformatf("rand%0d onehot", c), 32'($countones(~GNT) <= 1), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central arbiter for the shared PCI AD/CBE/FRAME/IRDY bus. Targets such as the Device memory target sit on this bus.
- Accepts active-low REQ lines from up to N_MASTERS initiators and drives active-low GNT lines.
- Uses rotating (round-robin) priority and bus parking.
- Watches FRAME/IRDY so that grants are only handed over across an idle bus with one turnaround cycle.

Parameters:
- N_MASTERS, 4: number of initiators; legal range 2..8.
- PARK_MASTER, 0: index granted when there are no requests.
- GNT_TIMEOUT, 16: cycles a granted master may hold GNT without asserting FRAME before GNT is revoked.
- ID_W, 2: width of GNT_ID; must be at least clog2(N_MASTERS).

Ports:
- CLK  input  1  bus clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  N_MASTERS  per-master request, active low.
- FRAME  input  1  bus FRAME, active low.
- IRDY  input  1  bus IRDY, active low.
- GNT  output  N_MASTERS  per-master grant, active low; at most one bit low at any time.
- GNT_ID  output  ID_W  index of the currently granted master; valid when any GNT bit is low.
- BUS_BUSY  output  1  high while the arbiter is in the BUSY state.
- TIMEOUT_ERR  output  1  one-cycle pulse when a grant is revoked by GNT_TIMEOUT.

Behaviour:
- Reset (RST low, asynchronous):
  - GNT = all ones, GNT_ID = 0, BUS_BUSY = 0, TIMEOUT_ERR = 0.
  - state = ARB, last winner pointer LAST = N_MASTERS-1, so master 0 has top priority first.
  - Internal timeout counter = 0.
- Bus idle condition: FRAME==1 && IRDY==1, sampled on the rising edge.
- Winner selection: search REQ from index LAST+1 upward, wrapping modulo N_MASTERS and ending at LAST. The first low bit wins.
- ARB state (the turnaround cycle; all GNT high for exactly this one cycle):
  - No REQ low: go to PARK.
  - Otherwise go to GRANT with the winner.
- PARK state:
  - GNT[PARK_MASTER] = 0, GNT_ID = PARK_MASTER.
  - FRAME sampled low (the parked master starts a transaction): go to BUSY and set LAST = PARK_MASTER.
  - Else any REQ low (including PARK_MASTER's own) and bus idle:
    - If the winner is PARK_MASTER, go to GRANT directly with no turnaround.
    - Otherwise go to ARB.
- GRANT state:
  - GNT[w] = 0; the timeout counter increments each cycle.
  - FRAME sampled low: go to BUSY, set LAST = w, clear the counter.
  - Else REQ[w] sampled high (request withdrawn): go to ARB.
  - Else counter reaches GNT_TIMEOUT-1: go to ARB, pulse TIMEOUT_ERR for 1 cycle, leave LAST unchanged.
- BUSY state:
  - BUS_BUSY = 1.
  - GNT[w] stays low while no other REQ is low.
  - If any other REQ is low, GNT[w] goes high on the next cycle; the current transaction continues (PCI early grant removal). GNT is never reasserted within the same BUSY period.
  - Bus idle sampled: go to ARB.
- Latency:
  - REQ low to GNT low is 2 cycles from idle/PARK: ARB, then GRANT registered.
  - Bus idle to the next GNT is 2 cycles: ARB, then GRANT.
- Simultaneous events:
  - In GRANT, FRAME low and REQ[w] high in the same cycle: FRAME wins, go to BUSY.
  - FRAME low on the timeout cycle: FRAME wins, no error.
- All GNT and status outputs are registered; there is no combinational path from REQ to GNT.
- Reset mid-transaction releases all grants immediately (asynchronous). The arbiter restarts in ARB without waiting for bus idle.
- REQ bits at or above N_MASTERS do not exist. The one-hot-low GNT invariant must hold on every cycle; the verifier asserts it.

Test Plan:
- Reset then no requests (REQ=4'b1111): GNT=4'b1111 for 1 cycle (ARB), then GNT=4'b1110 (park on 0), GNT_ID=0, BUS_BUSY=0.
- From PARK, REQ=4'b1011 (master 2), bus idle:
  - Required: GNT=1111 for 1 cycle, then GNT=1011, GNT_ID=2.
  - Then FRAME low: next cycle BUS_BUSY=1.
  - Then FRAME=IRDY=1: next cycle GNT=1111, followed by park.
- Round-robin, REQ=4'b0000 held and each master runs a 3-cycle transaction: grant order is 0,1,2,3,0 with exactly one all-high GNT cycle between grants.
- Early removal: master 1 in BUSY and REQ[3] goes low. Required: GNT[1] high one cycle later while FRAME is still low; GNT=0111 two cycles after bus idle.
- Timeout: grant master 2, hold FRAME high for 16 cycles. Required: TIMEOUT_ERR pulses once at cycle 16, GNT=1111, LAST unchanged (master 3 wins next if requesting).
- Asynchronous reset asserted mid-BUSY between clock edges: GNT=1111 and BUS_BUSY=0 immediately, before the next CLK edge.
